led_7seg_scan: RTL and testbench

LED_7SEG_SCAN -- requirements
Module: led_7seg_scan

---
 rtl/led_7seg_scan.sv | 104 ++++++++++
 tb/tb_led_7seg_scan.sv | 123 ++++++++++++
 2 files changed

// File: rtl/led_7seg_scan.sv
// led_7seg_scan: four-digit multiplexed 7-segment driver with anti-ghost blanking,
// leading-zero suppression and frame-aligned double-buffered updates.
module led_7seg_scan #(
    parameter int SCAN_DIV  = 33250,
    parameter int BLANK_CYC = 64,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic [3:0]  dig_en,
    output logic        frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

    typedef enum logic {BLANK, SHOW} state_t;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp, pbuf;
    logic [3:0]    disp_dp, pbuf_dp;
    logic          pend;
    logic          tick, bnd;
    state_t        st;
    logic [3:0]    cur, sup;
    logic [6:0]    dec;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        tick = cnt == LAST;
        bnd  = tick && idx == 2'd3;
        st   = cnt < BLK ? BLANK : SHOW;
        cur  = disp[{idx, 2'b00} +: 4];
        dec  = decode(cur);
        // a digit is dark when it and every more-significant digit are zero
        sup[3] = disp[15:12] == 4'd0;
        sup[2] = sup[3] && disp[11:8] == 4'd0;
        sup[1] = sup[2] && disp[7:4] == 4'd0;
        sup[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            disp        <= '0;
            disp_dp     <= '0;
            pbuf        <= '0;
            pbuf_dp     <= '0;
            pend        <= 1'b0;
            seg         <= '0;
            seg_dp      <= 1'b0;
            dig_en      <= '0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= idx + 1'b1;
            // display data only changes on the frame boundary so a frame is never torn
            if (bnd) begin
                if (load) begin
                    disp    <= digits_in;
                    disp_dp <= dp_in;
                end else if (pend) begin
                    disp    <= pbuf;
                    disp_dp <= pbuf_dp;
                end
                pend <= 1'b0;
            end else if (load) begin
                pbuf    <= digits_in;
                pbuf_dp <= dp_in;
                pend    <= 1'b1;
            end
            load_ack    <= bnd && (load || pend);
            frame_start <= bnd;
            dig_en      <= st == SHOW ? 4'b0001 << idx : 4'b0000;
            seg_dp      <= st == SHOW && disp_dp[idx];
            seg         <= st == SHOW && !(BLANK_LZ && sup[idx]) ? dec : 7'b0000000;
        end
    end
endmodule

// File: tb/tb_led_7seg_scan.sv
// tb_led_7seg_scan: directed checks of scan timing, blanking, buffered loads and reset
// with SCAN_DIV=8 and BLANK_CYC=2 (32-cycle frame).
module tb_led_7seg_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        load_ack, seg_dp, frame_start;
    logic [6:0]  seg;
    logic [3:0]  dig_en;

    int checks = 0;
    int failures = 0;
    int k = 0;

    led_7seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .load_ack(load_ack), .seg(seg), .seg_dp(seg_dp), .dig_en(dig_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic go(input int t);
        while (k < t) step();
    endtask

    // {dig_en, seg_dp, seg}
    task automatic disp_chk(input string tag, input logic [3:0] d, input logic p, input logic [6:0] s);
        chk(tag, {4'b0, dig_en, seg_dp, seg}, {4'b0, d, p, s});
    endtask

    task automatic pulse_chk(input string tag, input logic a, input logic f);
        chk(tag, {14'b0, load_ack, frame_start}, {14'b0, a, f});
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in = p;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        disp_chk("reset_disp", 4'b0000, 1'b0, 7'b0000000);
        pulse_chk("reset_pulse", 1'b0, 1'b0);
        rst = 1'b0;
        k = 0;
        // power-up frame: "0" on digit 0, others dark but scanned
        go(1);  disp_chk("pu_blank1", 4'b0000, 1'b0, 7'b0000000);
        go(2);  disp_chk("pu_blank2", 4'b0000, 1'b0, 7'b0000000);
        go(3);  disp_chk("pu_s0_first", 4'b0001, 1'b0, 7'b1111110);
        go(8);  disp_chk("pu_s0_last", 4'b0001, 1'b0, 7'b1111110);
        go(9);  disp_chk("pu_s1_blank", 4'b0000, 1'b0, 7'b0000000);
        go(11); disp_chk("pu_s1", 4'b0010, 1'b0, 7'b0000000);
        go(19); disp_chk("pu_s2", 4'b0100, 1'b0, 7'b0000000);
        go(27); disp_chk("pu_s3", 4'b1000, 1'b0, 7'b0000000);
        go(31); pulse_chk("pu_pre_bnd", 1'b0, 1'b0);
        go(32); pulse_chk("pu_bnd", 1'b0, 1'b1);
        // mid-frame load is held until the boundary
        go(33); do_load(16'h1234, 4'b0100);
        go(35); disp_chk("l1_old_s0", 4'b0001, 1'b0, 7'b1111110);
        go(63); pulse_chk("l1_pre_bnd", 1'b0, 1'b0);
        go(64); pulse_chk("l1_ack", 1'b1, 1'b1);
        go(65); pulse_chk("l1_ack_end", 1'b0, 1'b0);
        go(67); disp_chk("l1_s0", 4'b0001, 1'b0, 7'b0110011);
        go(75); disp_chk("l1_s1", 4'b0010, 1'b0, 7'b1111001);
        go(83); disp_chk("l1_s2", 4'b0100, 1'b1, 7'b1101101);
        go(91); disp_chk("l1_s3", 4'b1000, 1'b0, 7'b0110000);
        go(96); pulse_chk("l1_no_ack", 1'b0, 1'b1);
        // two loads in one frame: last wins, one ack
        go(99);  do_load(16'h0001, 4'b0000);
        go(109); do_load(16'h0042, 4'b0000);
        go(128); pulse_chk("l2_ack", 1'b1, 1'b1);
        go(129); pulse_chk("l2_ack_end", 1'b0, 1'b0);
        go(131); disp_chk("l2_s0", 4'b0001, 1'b0, 7'b1101101);
        go(139); disp_chk("l2_s1", 4'b0010, 1'b0, 7'b0110011);
        go(147); disp_chk("l2_s2_lz", 4'b0100, 1'b0, 7'b0000000);
        go(155); disp_chk("l2_s3_lz", 4'b1000, 1'b0, 7'b0000000);
        go(160); pulse_chk("l2_single_ack", 1'b0, 1'b1);
        // load exactly on the boundary cycle is captured directly
        go(191); do_load(16'h00A7, 4'b0000);
        pulse_chk("l3_ack", 1'b1, 1'b1);
        go(193); pulse_chk("l3_ack_end", 1'b0, 1'b0);
        go(195); disp_chk("l3_s0", 4'b0001, 1'b0, 7'b1110000);
        go(203); disp_chk("l3_s1_code_a", 4'b0010, 1'b0, 7'b0000000);
        go(211); disp_chk("l3_s2_lz", 4'b0100, 1'b0, 7'b0000000);
        go(224); pulse_chk("l3_no_pend", 1'b0, 1'b1);
        // reset while a load is pending discards it
        go(229); do_load(16'h9999, 4'b1111);
        go(235);
        rst = 1'b1;
        step();
        step();
        disp_chk("r_disp", 4'b0000, 1'b0, 7'b0000000);
        pulse_chk("r_pulse", 1'b0, 1'b0);
        rst = 1'b0;
        k = 0;
        go(3);  disp_chk("r_s0", 4'b0001, 1'b0, 7'b1111110);
        go(11); disp_chk("r_s1", 4'b0010, 1'b0, 7'b0000000);
        go(32); pulse_chk("r_no_ack", 1'b0, 1'b1);
        go(35); disp_chk("r_s0_after", 4'b0001, 1'b0, 7'b1111110);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
